// File: rtl/nios_onchip_mem_arbiter.sv
// Two-requester Avalon-MM arbiter sharing one single-port on-chip RAM between
// the Nios data master (m0) and the video/DMA reader (m1).
module nios_onchip_mem_arbiter #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int RR_MODE      = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam logic [7:0] STARVE_LIM_C = 8'(STARVE_LIMIT);

    logic       req0_s;
    logic       req1_s;
    logic       gnt0_s;
    logic       gnt1_s;
    logic       last_r;
    logic [7:0] starve_r;
    logic [1:0] rdv_r;

    // Grant decision from current requests plus arbitration history; nothing is granted in reset.
    always_comb begin
        req0_s = m0_read | m0_write;
        req1_s = m1_read | m1_write;
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (req0_s && req1_s) begin
            if (RR_MODE != 0) begin
                if (last_r) begin
                    gnt0_s = 1'b1;
                end else begin
                    gnt1_s = 1'b1;
                end
            end else begin
                if (starve_r >= STARVE_LIM_C) begin
                    gnt1_s = 1'b1;
                end else begin
                    gnt0_s = 1'b1;
                end
            end
        end else if (req0_s) begin
            gnt0_s = 1'b1;
        end else if (req1_s) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Arbitration history, m1 starvation counter and read-valid pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r   <= 1'b0;
            starve_r <= 8'd0;
            rdv_r    <= 2'b00;
        end else begin
            if (gnt0_s) begin
                last_r <= 1'b0;
            end else if (gnt1_s) begin
                last_r <= 1'b1;
            end else begin
                last_r <= last_r;
            end
            if (req1_s && !gnt1_s) begin
                starve_r <= (starve_r == 8'hFF) ? starve_r : starve_r + 8'd1;
            end else begin
                starve_r <= 8'd0;
            end
            // A read+write collision is a write, so it never returns data.
            rdv_r <= {gnt1_s & m1_read & ~m1_write, gnt0_s & m0_read & ~m0_write};
        end
    end

    // Memory-side mux from the granted port; all zero when idle.
    always_comb begin
        mem_chipselect = gnt0_s | gnt1_s;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        if (gnt0_s) begin
            mem_write      = m0_write;
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
        end else if (gnt1_s) begin
            mem_write      = m1_write;
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
        end else begin
            mem_write = 1'b0;
        end
    end

    // Gating with reset suppresses a read accepted just before reset asserted.
    assign m0_waitrequest   = reset | (req0_s & ~gnt0_s);
    assign m1_waitrequest   = reset | (req1_s & ~gnt1_s);
    assign m0_readdatavalid = rdv_r[0] & ~reset;
    assign m1_readdatavalid = rdv_r[1] & ~reset;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_nios_onchip_mem_arbiter.sv
// Directed bench: round-robin instance backed by a byte-enabled RAM model, plus
// a fixed-priority instance (STARVE_LIMIT=3) for the starvation guard.
module tb_nios_onchip_mem_arbiter;

    logic        clk;
    logic        reset;
    int          checks;
    int          errors;

    logic [13:0] m0_address, m1_address, mem_address;
    logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, mem_writedata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata, mem_readdata;
    logic        mem_chipselect, mem_write;

    logic [13:0] f0_address, f1_address, f_mem_address;
    logic [3:0]  f_mem_byteenable;
    logic        f0_read, f1_read;
    logic        f0_waitrequest, f1_waitrequest, f0_readdatavalid, f1_readdatavalid;
    logic [31:0] f0_readdata, f1_readdata, f_mem_writedata;
    logic        f_mem_chipselect, f_mem_write;

    logic [31:0] ram [0:16383];

    nios_onchip_mem_arbiter #(.ADDR_W(14), .DATA_W(32), .RR_MODE(1), .STARVE_LIMIT(8)) dut_rr (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    nios_onchip_mem_arbiter #(.ADDR_W(14), .DATA_W(32), .RR_MODE(0), .STARVE_LIMIT(3)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_address(f0_address), .m0_byteenable(4'hF), .m0_read(f0_read),
        .m0_write(1'b0), .m0_writedata(32'h0), .m0_waitrequest(f0_waitrequest),
        .m0_readdata(f0_readdata), .m0_readdatavalid(f0_readdatavalid),
        .m1_address(f1_address), .m1_byteenable(4'hF), .m1_read(f1_read),
        .m1_write(1'b0), .m1_writedata(32'h0), .m1_waitrequest(f1_waitrequest),
        .m1_readdata(f1_readdata), .m1_readdatavalid(f1_readdatavalid),
        .mem_address(f_mem_address), .mem_byteenable(f_mem_byteenable),
        .mem_chipselect(f_mem_chipselect), .mem_write(f_mem_write),
        .mem_writedata(f_mem_writedata), .mem_readdata(32'h0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: byte-enabled write, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic g;
        logic prev;
        logic [7:0] fp_seq;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
        ram[16'h0010] = 32'hDEADBEEF;
        mem_readdata = 32'h0;
        reset = 1'b1;
        m0_address = '0; m0_byteenable = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0;
        m1_address = '0; m1_byteenable = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0;
        f0_address = 14'h0AAA; f1_address = 14'h1555; f0_read = 1'b0; f1_read = 1'b0;

        next_cycle();
        next_cycle();
        #1;
        chk("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
        chk("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
        chk("rst_cs", 32'(mem_chipselect), 32'd0);
        chk("rst_m0_rdv", 32'(m0_readdatavalid), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);

        // Single read of 0x0010
        next_cycle();
        reset = 1'b0; m0_read = 1'b1; m0_address = 14'h0010;
        #1;
        chk("rd_m0_wait", 32'(m0_waitrequest), 32'd0);
        chk("rd_cs", 32'(mem_chipselect), 32'd1);
        chk("rd_addr", 32'(mem_address), 32'h0010);
        chk("rd_memwr", 32'(mem_write), 32'd0);
        next_cycle();
        m0_read = 1'b0;
        #1;
        chk("rd_m0_rdv", 32'(m0_readdatavalid), 32'd1);
        chk("rd_m0_data", m0_readdata, 32'hDEADBEEF);
        chk("rd_m1_rdv", 32'(m1_readdatavalid), 32'd0);

        // Byte-enabled write then readback of 0x3FFF
        next_cycle();
        m1_write = 1'b1; m1_address = 14'h3FFF; m1_byteenable = 4'b0101; m1_writedata = 32'h11223344;
        #1;
        chk("wr_m1_wait", 32'(m1_waitrequest), 32'd0);
        chk("wr_memwr", 32'(mem_write), 32'd1);
        chk("wr_be", 32'(mem_byteenable), 32'h5);
        chk("wr_wdata", mem_writedata, 32'h11223344);
        next_cycle();
        m1_write = 1'b0; m1_read = 1'b1;
        #1;
        chk("wr_no_rdv", 32'(m1_readdatavalid), 32'd0);
        next_cycle();
        m1_read = 1'b0;
        #1;
        chk("wr_rb_rdv", 32'(m1_readdatavalid), 32'd1);
        chk("wr_rb_data", m1_readdata, 32'h00220044);

        // Round-robin contention straight after reset: m1 first, then alternate
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0; m0_read = 1'b1; m0_address = 14'h0010; m1_read = 1'b1; m1_address = 14'h3FFF;
        prev = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) next_cycle();
            g = (k % 2 == 0);
            #1;
            chk($sformatf("rr_m0_wait%0d", k), 32'(m0_waitrequest), 32'(g));
            chk($sformatf("rr_m1_wait%0d", k), 32'(m1_waitrequest), 32'(!g));
            if (k > 0) begin
                chk($sformatf("rr_m0_rdv%0d", k), 32'(m0_readdatavalid), 32'(!prev));
                chk($sformatf("rr_m1_rdv%0d", k), 32'(m1_readdatavalid), 32'(prev));
                chk($sformatf("rr_data%0d", k), m0_readdata, prev ? 32'h00220044 : 32'hDEADBEEF);
            end
            prev = g;
        end
        next_cycle();
        m0_read = 1'b0; m1_read = 1'b0;
        #1;
        chk("rr_last_m0_rdv", 32'(m0_readdatavalid), 32'd1);
        chk("rr_last_m1_rdv", 32'(m1_readdatavalid), 32'd0);

        // Reset in the cycle after an m0 read is accepted
        next_cycle();
        m0_read = 1'b1;
        #1;
        chk("mid_acc", 32'(m0_waitrequest), 32'd0);
        next_cycle();
        reset = 1'b1; m0_read = 1'b0;
        m1_write = 1'b1; m1_byteenable = 4'hF; m1_writedata = 32'hFFFFFFFF;
        #1;
        chk("mid_rdv", 32'(m0_readdatavalid), 32'd0);
        chk("mid_m0_wait", 32'(m0_waitrequest), 32'd1);
        chk("mid_m1_wait", 32'(m1_waitrequest), 32'd1);
        chk("mid_cs", 32'(mem_chipselect), 32'd0);
        chk("mid_memwr", 32'(mem_write), 32'd0);
        next_cycle();
        #1;
        chk("mid_rdv2", 32'(m0_readdatavalid), 32'd0);
        next_cycle();
        reset = 1'b0; m1_write = 1'b0; m1_read = 1'b1; m0_read = 1'b1;
        #1;
        chk("post_m1_gnt", 32'(m1_waitrequest), 32'd0);
        chk("post_m0_wait", 32'(m0_waitrequest), 32'd1);
        next_cycle();
        m0_read = 1'b0; m1_read = 1'b0;
        #1;
        chk("post_m1_rdv", 32'(m1_readdatavalid), 32'd1);
        chk("post_no_rst_wr", m1_readdata, 32'h00220044);

        // Read+write collision is treated as a write
        next_cycle();
        m0_read = 1'b1; m0_write = 1'b1; m0_address = 14'h0020;
        m0_byteenable = 4'hF; m0_writedata = 32'hCAFEF00D;
        #1;
        chk("col_memwr", 32'(mem_write), 32'd1);
        chk("col_wdata", mem_writedata, 32'hCAFEF00D);
        next_cycle();
        m0_write = 1'b0;
        #1;
        chk("col_no_rdv", 32'(m0_readdatavalid), 32'd0);
        next_cycle();
        m0_read = 1'b0;
        #1;
        chk("col_rb_rdv", 32'(m0_readdatavalid), 32'd1);
        chk("col_rb_data", m0_readdata, 32'hCAFEF00D);

        // Fixed priority, STARVE_LIMIT=3: m0,m0,m0,m1 repeating
        fp_seq = 8'b1000_1000;
        next_cycle();
        f0_read = 1'b1; f1_read = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) next_cycle();
            g = fp_seq[k];
            #1;
            chk($sformatf("fp_m0_wait%0d", k), 32'(f0_waitrequest), 32'(g));
            chk($sformatf("fp_m1_wait%0d", k), 32'(f1_waitrequest), 32'(!g));
            chk($sformatf("fp_addr%0d", k), 32'(f_mem_address), g ? 32'h1555 : 32'h0AAA);
        end
        next_cycle();
        f0_read = 1'b0; f1_read = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_onchip_mem_arbiter.md
Name: nios_onchip_mem_arbiter

Overview:
- Two-requester Avalon-MM arbiter that shares one single-port on-chip RAM (16384 x 32, byte-enabled, 1-cycle read latency) between the Nios data master (m0) and the air-hockey video/DMA reader (m1).
- Grants at most one transfer per clock, holds the loser with waitrequest, and routes read data back to its owner with readdatavalid.
- Sits between the interconnect masters and the RAM's s1 slave port.

Parameters:
- ADDR_W, 14, word address width, matching RAM depth 16384.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- RR_MODE, 1, 1 = round-robin; 0 = fixed priority to m0 with starvation guard.
- STARVE_LIMIT, 8, fixed-priority mode only: consecutive m1 wait cycles before m1 is forced a grant; range 1..255.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- m0_address / m1_address  in  ADDR_W  requester word address.
- m0_byteenable / m1_byteenable  in  DATA_W/8  write byte lanes.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_writedata / m1_writedata  in  DATA_W  write data.
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle.
- m0_readdata / m1_readdata  out  DATA_W  read data, valid only with readdatavalid.
- m0_readdatavalid / m1_readdatavalid  out  1  read data valid strobe.
- mem_address  out  ADDR_W  to RAM address.
- mem_byteenable  out  DATA_W/8  to RAM byteenable.
- mem_chipselect  out  1  to RAM chipselect.
- mem_write  out  1  to RAM write.
- mem_writedata  out  DATA_W  to RAM writedata.
- mem_readdata  in  DATA_W  from RAM, valid 1 cycle after the address is presented.

Behaviour:
- Request definition: req_n = mN_read | mN_write. If read and write are both high, the transfer is a write and no readdatavalid is produced.
- Grant is combinational from the current requests plus registered state; at most one of gnt0/gnt1 is high per cycle.
  - Only one port requesting: that port is granted.
  - Both requesting, RR_MODE=1: grant the port that is not last_q. last_q is a 1-bit register updated to the granted port on every grant; reset value 0, so m1 wins the first contested cycle.
  - Both requesting, RR_MODE=0: grant m0, unless starve_q >= STARVE_LIMIT, in which case grant m1.
- starve_q is an 8-bit counter with reset value 0.
  - Increments, saturating at 255, each cycle m1 requests and is not granted.
  - Clears when m1 is granted or m1 is not requesting.
  - Unused but harmless when RR_MODE=1.
- mN_waitrequest = req_n & ~gnt_n. It is 0 when the port is idle or granted. During reset both waitrequests are forced to 1.
- Memory side: mem_chipselect = gnt0 | gnt1 (0 in reset); mem_write = granted port's write. mem_address, mem_byteenable and mem_writedata are muxed from the granted port and are 0 when nothing is granted.
- Read latency is exactly 1 cycle after acceptance.
  - rdv_q[1:0] registers (gnt_n & read & ~write) per port; reset 00.
  - mN_readdatavalid = rdv_q[N].
  - mN_readdata = mem_readdata, shared and unregistered.
- Back-to-back reads by the same or alternating ports are accepted every cycle (full throughput, no bubbles).
- Reset mid-operation:
  - rdv_q clears, so a read accepted in the cycle before reset asserts never produces readdatavalid.
  - last_q returns to 0 and starve_q to 0.
  - No memory write is issued in any reset cycle.
- A requester held in waitrequest must keep its command stable; the arbiter does not latch commands.
- Output reset values: waitrequests 1; readdatavalids 0; all mem_* outputs 0.

Test Plan:
- Single read: m0_read=1, address 0x0010, RAM word 0xDEADBEEF → m0_waitrequest=0 same cycle; m0_readdatavalid=1 and m0_readdata=0xDEADBEEF the next cycle; m1 strobes stay 0.
- Byte write then read: m1_write=1, byteenable=0b0101, writedata=0x11223344 to 0x3FFF (initially 0) → read of 0x3FFF returns 0x00220044.
- Round-robin contention (RR_MODE=1): both ports read continuously for 6 cycles after reset → grants m1,m0,m1,m0,m1,m0; each waitrequest alternates; readdatavalid alternates 1 cycle behind.
- Fixed priority with starvation guard (RR_MODE=0, STARVE_LIMIT=3): both ports request continuously → grants m0,m0,m0,m1,m0,m0,m0,m1; starve_q peaks at 3.
- Reset mid-read: m0 read accepted at cycle N, reset=1 at cycle N+1 → no m0_readdatavalid; during reset both waitrequests are 1 and mem_chipselect is 0; the first grant after reset follows last_q=0.
- Read+write collision: m0_read=1 and m0_write=1 together with data 0xCAFEF00D → mem_write=1, the RAM is updated, and no readdatavalid is produced.
